// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter: FSM state encoding.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, registered read data one cycle after rd_en_i; DEPTH must be a power of two.
// Push when full / pop when empty are dropped and latch the sticky err_o flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             err_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             err_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = rd_data_q;
    assign err_o     = err_q;

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
            if ((wr_en_i && full_o) || (rd_en_i && empty_o)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while clr_i is low, bit_end_o on the last count.
// Wraps only through its own bit_end clear or clr_i; no overflow path.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign bit_end_o = !clr_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a 1-cycle-latency FIFO and serializes them as UART frames (start, LSB-first data, opt. even parity, stop).
// Pops only when enable_i && !fifo_empty_i in IDLE or the final stop cycle; tx_o is registered.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT),
    parameter int IDX_WIDTH    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rd_data_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 cnt_clr;
    logic                 start_ok;

    assign start_ok = enable_i && !fifo_empty_i;
    // Counter idles at zero outside the bit-timed states, so START always begins at count 0.
    assign cnt_clr  = !(state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_baud (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (cnt_clr),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        unique case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d = fifo_rd_data_i;
                par_d   = ^fifo_rd_data_i;
                idx_d   = '0;
                state_d = ST_START;
            end
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = start_ok ? ST_FETCH : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Line level is computed for the state being entered so the register tracks state_q exactly.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o         = tx_q;
    assign fifo_rd_en_o = (state_q == ST_FETCH);
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: two FIFO+transmitter pairs (no parity / even parity, 4 clocks per bit) checked by a frame-decoding scoreboard.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_fifo = 1'b1;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
    logic [7:0] wr_dat_a = '0, wr_dat_b = '0;
    logic [7:0] rdat_a, rdat_b;
    logic       empty_a, empty_b, full_a, full_b, ferr_a, ferr_b;
    logic       rd_en_a, rd_en_b, tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt_a = 0, rd_cnt_b = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int starts_a[$];
    int starts_b[$];

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH(8)) u_fifo_a (
        .clk_i(clk), .rst_i(rst_fifo), .wr_en_i(wr_en_a), .wr_data_i(wr_dat_a),
        .rd_en_i(rd_en_a), .rd_data_o(rdat_a), .empty_o(empty_a), .full_o(full_a), .err_o(ferr_a)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut (
        .clk_i(clk), .rst_i(rst_a), .enable_i(en_a), .fifo_empty_i(empty_a),
        .fifo_rd_data_i(rdat_a), .fifo_rd_en_o(rd_en_a), .tx_o(tx_a),
        .busy_o(busy_a), .frame_done_o(fd_a)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(8)) u_fifo_b (
        .clk_i(clk), .rst_i(rst_fifo), .wr_en_i(wr_en_b), .wr_data_i(wr_dat_b),
        .rd_en_i(rd_en_b), .rd_data_o(rdat_b), .empty_o(empty_b), .full_o(full_b), .err_o(ferr_b)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_par (
        .clk_i(clk), .rst_i(rst_b), .enable_i(en_b), .fifo_empty_i(empty_b),
        .fifo_rd_data_i(rdat_b), .fifo_rd_en_o(rd_en_b), .tx_o(tx_b),
        .busy_o(busy_b), .frame_done_o(fd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic get_tx(input bit w);
        return w ? tx_b : tx_a;
    endfunction

    function automatic logic get_rst(input bit w);
        return w ? rst_b : rst_a;
    endfunction

    function automatic logic get_fd(input bit w);
        return w ? fd_b : fd_a;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rd_en_a) rd_cnt_a++;
        if (rd_en_b) rd_cnt_b++;
    end

    // Scoreboard monitor: decode each frame from the line and compare with the queued expectation.
    task automatic monitor(input bit w);
        int         nb;
        logic [10:0] bits;
        int         bad_hold;
        int         fd_sum;
        logic       fd_last;
        bit         aborted;
        logic [7:0] e;
        nb = w ? 11 : 10;
        forever begin
            @(negedge clk);
            if (get_rst(w) || get_tx(w)) continue;
            if (w) starts_b.push_back(cyc);
            else   starts_a.push_back(cyc);
            bits = '0;
            bad_hold = 0;
            fd_sum = 0;
            fd_last = 1'b0;
            aborted = 1'b0;
            for (int s = 0; s < nb * 4; s++) begin
                if (s != 0) @(negedge clk);
                if (get_rst(w)) begin
                    aborted = 1'b1;
                    break;
                end
                if (s % 4 == 0) bits[s/4] = get_tx(w);
                else if (get_tx(w) !== bits[s/4]) bad_hold++;
                if (get_fd(w)) fd_sum++;
                fd_last = get_fd(w);
            end
            if (aborted) continue;
            if ((w ? exp_b.size() : exp_a.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got data %0h expected no frame", bits[8:1]);
                continue;
            end
            e = w ? exp_b.pop_front() : exp_a.pop_front();
            check(w ? "par_data" : "data", {24'd0, bits[8:1]}, {24'd0, e});
            if (w) check("parity_bit", {31'd0, bits[9]}, {31'd0, ^e});
            check("stop_bit", {31'd0, bits[nb-1]}, 32'd1);
            check("bit_hold_4clk", bad_hold, 0);
            check("frame_done_pulse", {31'd0, (fd_sum == 1) && fd_last}, 32'd1);
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic push(input bit w, input logic [7:0] d);
        @(negedge clk);
        if (w) begin
            wr_en_b = 1'b1;
            wr_dat_b = d;
        end else begin
            wr_en_a = 1'b1;
            wr_dat_a = d;
        end
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    task automatic wait_idle(input bit w, input int budget);
        int n = 0;
        while ((w ? (exp_b.size() != 0 || busy_b) : (exp_a.size() != 0 || busy_a)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic wait_busy_a(input int budget);
        int n = 0;
        while (!busy_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_within_budget", {31'd0, n < budget}, 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        int rd0;
        int s0;
        int viol;
        repeat (3) @(negedge clk);
        rst_fifo = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'd0, tx_a}, 32'd1);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_rd_en", {31'd0, rd_en_a}, 32'd0);
        check("reset_frame_done", {31'd0, fd_a}, 32'd0);
        check("reset_tx_par", {31'd0, tx_b}, 32'd1);

        // Single frame 0xA5.
        rd0 = rd_cnt_a;
        en_a = 1'b1;
        exp_a.push_back(8'hA5);
        push(1'b0, 8'hA5);
        wait_idle(1'b0, 200);
        check("a5_rd_pulses", rd_cnt_a - rd0, 1);
        check("a5_busy_after", {31'd0, busy_a}, 32'd0);

        // Three back-to-back frames.
        rd0 = rd_cnt_a;
        s0 = starts_a.size();
        exp_a.push_back(8'h01);
        exp_a.push_back(8'h02);
        exp_a.push_back(8'h03);
        push(1'b0, 8'h01);
        push(1'b0, 8'h02);
        push(1'b0, 8'h03);
        wait_idle(1'b0, 400);
        check("b2b_rd_pulses", rd_cnt_a - rd0, 3);
        check("b2b_starts", starts_a.size() - s0, 3);
        if (starts_a.size() - s0 == 3) begin
            check("b2b_gap1", starts_a[s0+1] - starts_a[s0], 42);
            check("b2b_gap2", starts_a[s0+2] - starts_a[s0+1], 42);
        end
        check("b2b_fifo_empty", {31'd0, empty_a}, 32'd1);

        // Disabled with two words queued, then drop enable during DATA of frame 1.
        en_a = 1'b0;
        rd0 = rd_cnt_a;
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd_en_a || !tx_a || busy_a) viol++;
        end
        check("disabled_quiet", viol, 0);
        check("disabled_no_pop", rd_cnt_a - rd0, 0);
        exp_a.push_back(8'h11);
        en_a = 1'b1;
        wait_busy_a(10);
        repeat (8) @(negedge clk);
        en_a = 1'b0;
        wait_idle(1'b0, 200);
        repeat (20) @(negedge clk);
        check("drop_en_one_pop", rd_cnt_a - rd0, 1);
        check("drop_en_word_left", {31'd0, empty_a}, 32'd0);
        check("drop_en_idle", {31'd0, busy_a}, 32'd0);

        // Async reset mid-DATA; FIFO keeps its contents.
        rd0 = rd_cnt_a;
        push(1'b0, 8'h33);
        en_a = 1'b1;
        wait_busy_a(10);
        repeat (10) @(negedge clk);
        #2;
        rst_a = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx_a}, 32'd1);
        check("async_rst_busy", {31'd0, busy_a}, 32'd0);
        check("async_rst_rd_en", {31'd0, rd_en_a}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        exp_a.push_back(8'h33);
        rst_a = 1'b0;
        wait_idle(1'b0, 200);
        check("post_rst_pops", rd_cnt_a - rd0, 2);
        check("post_rst_empty", {31'd0, empty_a}, 32'd1);

        // Empty FIFO with enable held high.
        rd0 = rd_cnt_a;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_en_a || !tx_a) viol++;
        end
        check("empty_idle_quiet", viol, 0);
        check("empty_no_pop", rd_cnt_a - rd0, 0);

        // Even parity: 0x07 -> parity 1, 0x03 -> parity 0, back-to-back 46 cycles apart.
        en_b = 1'b1;
        exp_b.push_back(8'h07);
        exp_b.push_back(8'h03);
        push(1'b1, 8'h07);
        push(1'b1, 8'h03);
        wait_idle(1'b1, 400);
        check("par_starts", starts_b.size(), 2);
        if (starts_b.size() == 2) check("par_gap", starts_b[1] - starts_b[0], 46);
        check("par_rd_pulses", rd_cnt_b, 2);

        check("fifo_err_a", {31'd0, ferr_a}, 32'd0);
        check("fifo_err_b", {31'd0, ferr_b}, 32'd0);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
